// File: rtl/decoder2x4_stream.sv
// rtl/decoder2x4_stream.sv - streaming 2-to-4 one-hot decoder with 2-entry output buffer and per-line hit counters
module decoder2x4_stream #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           A,
    input  logic                 en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           Y,
    input  logic                 clr_cnt,
    output logic [4*CNT_W-1:0]   hit_cnt
);

    logic [3:0]       r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_hit [4];

    logic             w_push;
    logic             w_pop;
    logic [3:0]       w_word;

    assign in_ready  = ~rst & (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign Y         = out_valid ? r_mem[r_rd_ptr] : 4'b0000;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_word    = en ? (4'b0001 << A) : 4'b0000;

    // Storage itself is not reset: Y is gated by the occupancy count instead.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst || clr_cnt) begin
                r_hit[i] <= '0;
            end else if (w_pop && Y[i] && (r_hit[i] != {CNT_W{1'b1}})) begin
                r_hit[i] <= r_hit[i] + 1'b1;
            end
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            hit_cnt[i*CNT_W +: CNT_W] = r_hit[i];
        end
    end

endmodule

// File: tb/tb_decoder2x4_stream.sv
// tb/tb_decoder2x4_stream.sv - table, directed and random checks of decoder2x4_stream against a queue model
module tb_decoder2x4_stream;

    localparam int CNT_W = 2;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [1:0]         A = 2'd0;
    logic               en = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [3:0]         Y;
    logic               clr_cnt = 1'b0;
    logic [4*CNT_W-1:0] hit_cnt;

    decoder2x4_stream #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .en(en), .out_valid(out_valid), .out_ready(out_ready),
        .Y(Y), .clr_cnt(clr_cnt), .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [3:0] mq[$];
    int         mc[4];

    typedef struct {
        logic [1:0] a;
        logic       e;
        logic [3:0] y;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [4*CNT_W-1:0] model_hits();
        logic [4*CNT_W-1:0] h;
        h = '0;
        for (int i = 0; i < 4; i++) h[i*CNT_W +: CNT_W] = CNT_W'(mc[i]);
        return h;
    endfunction

    // One clock: drive inputs, compare DUT against the model, advance the model, step past the edge.
    task automatic cyc(input logic v, input logic [1:0] a, input logic e,
                       input logic ordy, input logic clr, input logic r);
        logic       acc;
        logic       pop;
        logic [3:0] w;
        rst = r; in_valid = v; A = a; en = e; out_ready = ordy; clr_cnt = clr;
        #1;
        check("in_ready", in_ready, !r && mq.size() < 2);
        check("out_valid", out_valid, mq.size() != 0);
        check("Y", Y, (mq.size() != 0) ? mq[0] : 4'b0000);
        check("hit_cnt", hit_cnt, model_hits());
        acc = v && !r && mq.size() < 2;
        pop = ordy && mq.size() != 0;
        if (r) begin
            mq.delete();
            for (int i = 0; i < 4; i++) mc[i] = 0;
        end else begin
            if (pop) begin
                w = mq.pop_front();
                for (int i = 0; i < 4; i++) if (w[i] && mc[i] < SAT) mc[i]++;
            end
            if (clr) for (int i = 0; i < 4; i++) mc[i] = 0;
            if (acc) mq.push_back(e ? 4'(1 << a) : 4'b0000);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{2'd0, 1'b1, 4'b0001};
        tbl[1] = '{2'd1, 1'b1, 4'b0010};
        tbl[2] = '{2'd2, 1'b1, 4'b0100};
        tbl[3] = '{2'd3, 1'b1, 4'b1000};
        tbl[4] = '{2'd2, 1'b0, 4'b0000};
        tbl[5] = '{2'd1, 1'b1, 4'b0010};
        for (int i = 0; i < 4; i++) mc[i] = 0;

        // Reset, then stream the table at full rate
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_Y", Y, 0);
        check("rst_hits", hit_cnt, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, tbl[k].a, tbl[k].e, 1, 0, 0);
            check("tbl_Y", Y, tbl[k].y);
            check("tbl_valid", out_valid, 1);
        end
        cyc(0, 0, 0, 1, 0, 0);
        check("stream_hits", hit_cnt, 8'b01_01_01_01);

        // Backpressure
        cyc(1, 2, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        check("bp_full_ready", in_ready, 0);
        check("bp_hold_Y", Y, 4'b0100);
        cyc(1, 3, 1, 0, 0, 0);
        check("bp_still_Y", Y, 4'b0100);
        cyc(0, 0, 0, 1, 0, 0);
        check("bp_second_Y", Y, 4'b0010);
        check("bp_ready_back", in_ready, 1);
        cyc(0, 0, 0, 1, 0, 0);
        check("bp_empty", out_valid, 0);
        check("bp_hits", hit_cnt, 8'b01_10_10_01);

        // Enable gating
        cyc(1, 3, 0, 0, 0, 0);
        check("en0_valid", out_valid, 1);
        check("en0_Y", Y, 0);
        cyc(1, 3, 1, 1, 0, 0);
        check("en1_Y", Y, 4'b1000);
        check("en0_nohit", hit_cnt, 8'b01_10_10_01);
        cyc(0, 0, 0, 1, 0, 0);
        check("en1_hit", hit_cnt, 8'b10_10_10_01);

        // Saturation then clear against a same-cycle hit
        for (int k = 0; k < 5; k++) cyc(1, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        check("sat_hit1", hit_cnt[1*CNT_W +: CNT_W], SAT);
        cyc(1, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        check("clr_prio", hit_cnt, 0);

        // Reset mid-operation
        cyc(1, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 2, 1, 0, 0, 0);
        cyc(1, 3, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 1);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_Y", Y, 0);
        check("mid_rst_hits", hit_cnt, 0);
        cyc(0, 0, 0, 1, 0, 0);
        check("post_rst_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);

        // Push and pop together at count 1
        cyc(1, 0, 1, 0, 0, 0);
        check("pp_head", Y, 4'b0001);
        cyc(1, 2, 1, 1, 0, 0);
        check("pp_Y", Y, 4'b0100);
        check("pp_ready", in_ready, 1);
        cyc(0, 0, 0, 0, 0, 0);
        check("pp_count1", in_ready, 1);
        cyc(0, 0, 0, 1, 0, 0);
        check("pp_drained", out_valid, 0);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 7) != 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
                $urandom_range(0, 150) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder2x4_stream.md
Name: decoder2x4_stream

Overview:
- Streaming 2-to-4 line decoder: converts a 2-bit binary code into a one-hot 4-bit word.
- It is the companion block to the team's 4-to-2 encoder and restores the line selects that the encoder compresses.
- Codes arrive on a valid/ready input and are decoded into a 2-entry output buffer, so upstream and downstream can stall independently.
- Per-line saturating hit counters give debug and coverage visibility of which lines were delivered.

Parameters:
- CNT_W, 8, width of each per-line hit counter (legal range 2..16).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream code valid.
- in_ready  output  1  block can accept a code this cycle.
- A  input  2  binary code to decode.
- en  input  1  decode enable, sampled with A; en=0 yields all-zero word.
- out_valid  output  1  decoded word available.
- out_ready  input  1  downstream accepts word.
- Y  output  4  decoded word (one-hot when en=1, 4'b0000 when en=0).
- clr_cnt  input  1  synchronous clear of all hit counters.
- hit_cnt  output  4*CNT_W  packed counters; line i at [i*CNT_W +: CNT_W].

Behaviour:
- Reset: synchronous, active-high, sampled on clk rising edge.
  - State after rst: buffer empty, out_valid=0, Y=4'b0000, all hit_cnt=0.
  - in_ready=0 while rst=1, so no code is accepted during reset.
  - rst asserted mid-stream discards all buffered words; nothing is emitted for them.
- Decode rule: Y[i]=en & (A==i).
  - A=0 -> 0001, A=1 -> 0010, A=2 -> 0100, A=3 -> 1000.
  - A is never X-propagated; only en gates the output.
- Input handshake:
  - Accept when in_valid & in_ready at a rising edge; the decoded word is pushed into the buffer.
  - in_ready = ~rst & (count != 2). It depends only on buffer state, never combinationally on out_ready.
- Buffer: 2-entry FIFO of decoded words; count is 0, 1 or 2.
  - Word at the head drives Y; out_valid = (count != 0).
  - Latency: a word accepted at edge N appears on Y with out_valid=1 after edge N when the buffer was empty. Minimum latency is 1 cycle.
  - Output handshake: the word is consumed when out_valid & out_ready at a rising edge.
  - Y and out_valid are held stable while out_valid=1 and out_ready=0.
  - Push+pop in the same cycle with count=1: count stays 1 and the new word becomes the head.
  - Full (count=2): in_ready=0, so no push. A pop the same cycle frees one entry; in_ready rises the next cycle.
  - Empty: out_ready is ignored and Y reads 4'b0000.
  - Ordering: strict FIFO, no reordering, no drops.
- Hit counters: on each output handshake, hit_cnt[i] increments for every i with Y[i]=1.
  - Words with en=0 (Y=0) count nothing.
  - Counters saturate at 2^CNT_W-1; there is no wrap.
  - clr_cnt=1 sets all counters to 0 at the edge and takes priority over a same-cycle increment.
  - Counters are not affected by buffer state otherwise.
- Throughput: 1 word/cycle sustained when out_ready is held at 1.

Test Plan:
- Reset then stream: rst 1 for 2 cycles, then A=0,1,2,3 with en=1 and out_ready=1 -> Y=0001,0010,0100,1000 in order. Each word appears 1 cycle after acceptance; hit_cnt each = 1.
- Backpressure: out_ready=0 and push A=2, A=1 -> after 2 pushes in_ready=0 and Y holds 0100. A third word (A=3) is not accepted. Raise out_ready -> 0100 then 0010 emitted, then in_ready=1.
- Enable gating: A=3, en=0 accepted -> out_valid=1, Y=0000, no hit_cnt change. Next A=3, en=1 -> Y=1000 and hit_cnt[3] increments.
- Saturation and clear (CNT_W=2): send A=1 five times -> hit_cnt[1]=3, not wrapped. Assert clr_cnt in the same cycle as a 6th A=1 handshake -> hit_cnt[1]=0.
- Reset mid-operation: buffer holds 2 words and rst is pulsed 1 cycle -> next cycle out_valid=0, Y=0000, hit_cnt=0. in_ready=0 during rst and 1 after.
- Simultaneous push/pop at count=1: head A=0 and push A=2 while out_ready=1 -> 0001 consumed, next cycle Y=0100 with count=1.
